step_motor_cmd_queue: RTL and testbench
=======================================

# step_motor_cmd_queue

Per-motor command sequencer placed directly upstream of one `step_motor` channel (drives its `sN_*` slave ports). It buffers queued move commands from the host or controller side. It issues each command as a start pulse with a stable step/speed/dir/ms set, and tracks the channel's `state` until the move completes. It handles abort, limit-triggered flush and start-acknowledge timeout.

## Interface
- `C_STEP_NUMBER_WIDTH`, 16: step count width.
- `C_SPEED_DATA_WIDTH`, 16: speed word width.
- `C_MICROSTEP_WIDTH`, 3: microstep field width.
- `C_FIFO_ADDR_WIDTH`, 3: FIFO depth is 2^N entries (default 8).
- `C_ACK_TIMEOUT`, 255: maximum cycles from `m_start` to `m_state` rising. Must exceed 2×`C_CLK_DIV_NBR`.
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
  - `clk`  in  1  sole clock.
  - `resetn`  in  1  asynchronous, active-low reset.
- Command input:
  - `cmd_valid`  in  1  command offered.
  - `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready` at a rising edge.
  - `cmd_step`  in  C_STEP_NUMBER_WIDTH  steps to move.
  - `cmd_speed`  in  C_SPEED_DATA_WIDTH  target speed.
  - `cmd_dir`  in  1  direction (1 = toward terminal).
  - `cmd_ms`  in  C_MICROSTEP_WIDTH  microstep mode.
- Control and status:
  - `abort`  in  1  single-cycle pulse: stop motor and flush queue.
  - `err_clr`  in  1  clears sticky flags.
  - `fifo_level`  out  C_FIFO_ADDR_WIDTH+1  queued entries.
  - `busy`  out  1  FSM not IDLE, or FIFO non-empty.
  - `done`  out  1  one-cycle pulse per completed or skipped command.
  - `err_timeout`  out  1  sticky: start not acknowledged.
  - `limit_hit`  out  1  sticky: limit sign seen during a move.
- Motor channel interface:
  - `m_start`  out  1  start pulse.
  - `m_stop`  out  1  stop pulse.
  - `m_step`  out  C_STEP_NUMBER_WIDTH  step count.
  - `m_speed`  out  C_SPEED_DATA_WIDTH  speed.
  - `m_dir`  out  1  direction.
  - `m_ms`  out  C_MICROSTEP_WIDTH  microstep mode.
  - `m_state`  in  1  motor running.
  - `m_zpsign`  in  1  zero-position sign.
  - `m_tpsign`  in  1  terminal-position sign.

## Operation
- Synchronous FIFO stores {step, speed, dir, ms}.
  - Push when `cmd_valid && cmd_ready`.
  - `cmd_ready = ~full & ~abort & rdy_en`. `rdy_en` is a flop that resets to 0 and is set to 1 on the first clock after reset.
  - Simultaneous push and pop on a full FIFO is not allowed, because ready is low when full.
  - Push and pop in the same cycle leaves `fifo_level` unchanged.
- FSM states: IDLE, ISSUE, WAIT_RUN, WAIT_DONE, WAIT_STOP.
  - **IDLE**: if the FIFO is non-empty and `m_state==0`, pop the head.
    - If `step==0`: pulse `done`, stay in IDLE, no start.
    - Otherwise: latch the fields into `m_*` registers and go to ISSUE.
  - **ISSUE**: `m_start=1` for exactly one cycle; clear the timeout counter; go to WAIT_RUN.
  - **WAIT_RUN**: on `m_state==1`, go to WAIT_DONE. If the counter reaches `C_ACK_TIMEOUT`: set `err_timeout`, flush the FIFO, go to IDLE.
  - **WAIT_DONE**: on `m_state==0`, pulse `done` and go to IDLE.
    - If `(m_dir & m_tpsign) | (~m_dir & m_zpsign)`: set `limit_hit` and flush the FIFO. Remain in WAIT_DONE; the motor stops itself.
  - **WAIT_STOP**: wait for `m_state==0`, then go to IDLE. No `done` pulse.
- `abort` in any state:
  - `m_stop=1` the next cycle, for exactly one cycle.
  - FIFO flushed.
  - FSM goes to WAIT_STOP if `m_state==1`, else to IDLE.
  - Abort takes priority over every other transition, push and timeout.
- While `err_timeout` or `limit_hit` is set, IDLE does not pop; the queue is held. `err_clr` clears both flags.
- `m_step/m_speed/m_dir/m_ms` hold their values from ISSUE until the next latch.

## Timing
- Reset: every output is 0, including `cmd_ready`. FIFO is empty and the FSM is in IDLE.
- A command accepted at edge k, into an empty queue with the motor idle, produces `m_start` high during cycle k+2. `m_*` fields are valid from cycle k+2.
- `done` is asserted the cycle after `m_state` is sampled 0 in WAIT_DONE.
- `m_start` and `m_stop` are registered and never both high.
- Timeout is counted in `clk` cycles, inclusive of the ISSUE cycle.
- Reset asserted mid-move: all outputs are 0 immediately (asynchronous), and the queue is lost.

## Structure
- Shared package/include `step_motor_pkg`: state encodings, width defaults and the command-word packing order {ms, dir, speed, step}.
- One sub-module `cmd_fifo`: a parameterized synchronous FIFO with asynchronous active-low reset, a flush input and a level output. The FSM, timeout counter and flags live in the top level.

## Test plan
- Push step=100, speed=0x200, dir=1, ms=2 with the motor idle → `m_start` pulses at k+2 with those values. Model raises `m_state` 40 cycles later and drops it 500 cycles later → one `done` pulse.
- Push 8 commands back-to-back, then a 9th → `cmd_ready` low on the 9th and `fifo_level`=8. The commands are issued in order, each only after the previous `m_state` falls.
- Push step=0 → `done` pulse, no `m_start`, `fifo_level` back to 0.
- Model never raises `m_state` → `err_timeout` set 255 cycles after `m_start`. The FIFO is flushed and the next push is held until `err_clr`.
- During WAIT_DONE with dir=1, assert `m_tpsign` → `limit_hit` set and the queue flushed. `done` follows the `m_state` fall.
- `abort` during a move with 3 queued → one-cycle `m_stop` and `fifo_level`=0. FSM waits for `m_state`=0, no `done`. A `cmd_valid` coincident with `abort` is not accepted.

Source files
------------

// File: rtl/step_motor_pkg.sv
// Shared definitions for the step_motor command queue: sequencer states,
// width defaults and the limit-sign helper.
package step_motor_pkg;

  localparam int unsigned SM_STEP_WIDTH   = 16;
  localparam int unsigned SM_SPEED_WIDTH  = 16;
  localparam int unsigned SM_MS_WIDTH     = 3;
  localparam int unsigned SM_FIFO_AW      = 3;
  localparam int unsigned SM_ACK_TIMEOUT  = 255;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_RUN  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_WAIT_STOP = 3'd4
  } state_t;

  // The end stop in the direction of travel, not the one behind the motor.
  function automatic logic limit_reached(input logic dir, input logic tpsign,
                                         input logic zpsign);
    return (dir & tpsign) | (~dir & zpsign);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead synchronous FIFO with flush and level output.
module cmd_fifo #(
  parameter int unsigned DATA_WIDTH = 36,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty & ~flush;
  // A push coincident with a flush survives as the sole entry at slot 0.
  assign wr_addr = flush ? '0 : wr_ptr;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_addr] <= din;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= do_push ? ADDR_WIDTH'(1) : '0;
      count  <= do_push ? (ADDR_WIDTH+1)'(1) : '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/step_motor_cmd_queue.sv
// Per-motor command sequencer: queues moves, issues them to one step_motor
// channel and supervises start acknowledge, completion, limits and abort.
module step_motor_cmd_queue
  import step_motor_pkg::*;
#(
  parameter int unsigned C_STEP_NUMBER_WIDTH = SM_STEP_WIDTH,
  parameter int unsigned C_SPEED_DATA_WIDTH  = SM_SPEED_WIDTH,
  parameter int unsigned C_MICROSTEP_WIDTH   = SM_MS_WIDTH,
  parameter int unsigned C_FIFO_ADDR_WIDTH   = SM_FIFO_AW,
  parameter int unsigned C_ACK_TIMEOUT       = SM_ACK_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] cmd_step,
  input  logic [C_SPEED_DATA_WIDTH-1:0]  cmd_speed,
  input  logic                           cmd_dir,
  input  logic [C_MICROSTEP_WIDTH-1:0]   cmd_ms,
  input  logic                           abort,
  input  logic                           err_clr,
  output logic [C_FIFO_ADDR_WIDTH:0]     fifo_level,
  output logic                           busy,
  output logic                           done,
  output logic                           err_timeout,
  output logic                           limit_hit,
  output logic                           m_start,
  output logic                           m_stop,
  output logic [C_STEP_NUMBER_WIDTH-1:0] m_step,
  output logic [C_SPEED_DATA_WIDTH-1:0]  m_speed,
  output logic                           m_dir,
  output logic [C_MICROSTEP_WIDTH-1:0]   m_ms,
  input  logic                           m_state,
  input  logic                           m_zpsign,
  input  logic                           m_tpsign
);

  localparam int unsigned CMD_W = C_MICROSTEP_WIDTH + 1 + C_SPEED_DATA_WIDTH
                                  + C_STEP_NUMBER_WIDTH;
  localparam int unsigned CNT_W = $clog2(C_ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_ACK_TIMEOUT - 1);

  state_t                         state;
  logic [CNT_W-1:0]               ack_cnt;
  logic                           rdy_en;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic                           fifo_push;
  logic                           fifo_pop;
  logic                           fifo_flush;
  logic [CMD_W-1:0]               fifo_din;
  logic [CMD_W-1:0]               fifo_dout;
  logic [C_STEP_NUMBER_WIDTH-1:0] head_step;
  logic [C_SPEED_DATA_WIDTH-1:0]  head_speed;
  logic                           head_dir;
  logic [C_MICROSTEP_WIDTH-1:0]   head_ms;
  logic                           ack_expired;
  logic                           limit_now;

  assign fifo_din = {cmd_ms, cmd_dir, cmd_speed, cmd_step};
  assign {head_ms, head_dir, head_speed, head_step} = fifo_dout;

  assign cmd_ready   = ~fifo_full & ~abort & rdy_en;
  assign fifo_push   = cmd_valid & cmd_ready;
  assign ack_expired = (state == ST_WAIT_RUN) & ~m_state & (ack_cnt == CNT_LAST);
  assign limit_now   = (state == ST_WAIT_DONE) & limit_reached(m_dir, m_tpsign, m_zpsign);
  assign fifo_flush  = abort | ack_expired | limit_now;
  assign fifo_pop    = (state == ST_IDLE) & ~fifo_empty & ~m_state & ~err_timeout
                       & ~limit_hit & ~abort;
  assign busy        = (state != ST_IDLE) | ~fifo_empty;

  cmd_fifo #(
    .DATA_WIDTH (CMD_W),
    .ADDR_WIDTH (C_FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (fifo_flush),
    .push   (fifo_push),
    .din    (fifo_din),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      ack_cnt     <= '0;
      rdy_en      <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      limit_hit   <= 1'b0;
      m_start     <= 1'b0;
      m_stop      <= 1'b0;
      m_step      <= '0;
      m_speed     <= '0;
      m_dir       <= 1'b0;
      m_ms        <= '0;
    end else begin
      rdy_en  <= 1'b1;
      m_start <= 1'b0;
      m_stop  <= 1'b0;
      done    <= 1'b0;
      // Clearing first lets a same-cycle timeout or limit event win.
      if (err_clr) begin
        err_timeout <= 1'b0;
        limit_hit   <= 1'b0;
      end
      if (abort) begin
        m_stop <= 1'b1;
        state  <= m_state ? ST_WAIT_STOP : ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (fifo_pop) begin
              if (head_step == '0) begin
                done <= 1'b1;
              end else begin
                m_step  <= head_step;
                m_speed <= head_speed;
                m_dir   <= head_dir;
                m_ms    <= head_ms;
                state   <= ST_ISSUE;
              end
            end
          end
          ST_ISSUE: begin
            m_start <= 1'b1;
            ack_cnt <= '0;
            state   <= ST_WAIT_RUN;
          end
          ST_WAIT_RUN: begin
            if (m_state) begin
              state <= ST_WAIT_DONE;
            end else if (ack_expired) begin
              err_timeout <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              ack_cnt <= ack_cnt + CNT_W'(1);
            end
          end
          ST_WAIT_DONE: begin
            if (limit_now) begin
              limit_hit <= 1'b1;
            end
            if (!m_state) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
          ST_WAIT_STOP: begin
            if (!m_state) begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_motor_cmd_queue.sv
// Randomised bench for step_motor_cmd_queue with a behavioural motor model
// and a scoreboard of commands expected to reach the motor.
module tb_step_motor_cmd_queue;

  typedef struct {
    logic [15:0] step;
    logic [15:0] speed;
    logic        dir;
    logic [2:0]  ms;
  } cmd_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_step = '0;
  logic [15:0] cmd_speed = '0;
  logic        cmd_dir = 1'b0;
  logic [2:0]  cmd_ms = '0;
  logic        abort = 1'b0;
  logic        err_clr = 1'b0;
  logic [3:0]  fifo_level;
  logic        busy, done, err_timeout, limit_hit, m_start, m_stop;
  logic [15:0] m_step, m_speed;
  logic        m_dir;
  logic [2:0]  m_ms;
  logic        m_state = 1'b0;
  logic        m_zpsign = 1'b0;
  logic        m_tpsign = 1'b0;

  always #5 clk = ~clk;

  step_motor_cmd_queue #(
    .C_STEP_NUMBER_WIDTH (16),
    .C_SPEED_DATA_WIDTH  (16),
    .C_MICROSTEP_WIDTH   (3),
    .C_FIFO_ADDR_WIDTH   (3),
    .C_ACK_TIMEOUT       (255)
  ) dut (
    .clk (clk), .resetn (resetn),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_step (cmd_step),
    .cmd_speed (cmd_speed), .cmd_dir (cmd_dir), .cmd_ms (cmd_ms),
    .abort (abort), .err_clr (err_clr), .fifo_level (fifo_level),
    .busy (busy), .done (done), .err_timeout (err_timeout), .limit_hit (limit_hit),
    .m_start (m_start), .m_stop (m_stop), .m_step (m_step), .m_speed (m_speed),
    .m_dir (m_dir), .m_ms (m_ms), .m_state (m_state), .m_zpsign (m_zpsign),
    .m_tpsign (m_tpsign)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          start_cyc = 0;
  int          n_starts = 0;
  int          n_dones = 0;
  cmd_t        exp_q[$];

  // Motor model knobs, set by the main sequence.
  bit ack_en = 1'b1;
  int ack_delay = 5;
  int run_len = 20;
  bit limit_stop = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.step  = 16'($urandom_range(1, 65535));
    c.speed = 16'($urandom);
    c.dir   = 1'($urandom);
    c.ms    = 3'($urandom);
    return c;
  endfunction

  // Motor: rises ack_delay cycles after a start, runs run_len cycles, and
  // winds down a few cycles after a stop or a limit.
  initial begin
    int   mph = 0;
    int   mt = 0;
    bit   stopping = 1'b0;
    bit   chk_done = 1'b0;
    bit   exp_done = 1'b0;
    cmd_t e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mph = 0; m_state = 1'b0; chk_done = 1'b0;
      end else begin
        if (chk_done) begin
          check_eq("done_after_fall", done, exp_done);
          chk_done = 1'b0;
        end
        if (done) n_dones++;
        if (m_start || m_stop) check_eq("start_stop_excl", m_start & m_stop, 0);
        if (m_start) begin
          n_starts++;
          start_cyc = cyc;
          check_eq("start_motor_idle", mph, 0);
          check_eq("start_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("m_step", m_step, e.step);
            check_eq("m_speed", m_speed, e.speed);
            check_eq("m_dir", m_dir, e.dir);
            check_eq("m_ms", m_ms, e.ms);
          end
          if (ack_en) begin mph = 1; mt = ack_delay; stopping = 1'b0; end
        end
        if (m_stop) begin
          if (mph == 1) mph = 0;
          else if (mph == 2) begin stopping = 1'b1; mt = 3; end
        end
        if (limit_stop && mph == 2) begin mt = 2; limit_stop = 1'b0; end
        case (mph)
          1: begin
            mt--;
            if (mt == 0) begin m_state = 1'b1; mph = 2; mt = run_len; end
          end
          2: begin
            mt--;
            if (mt == 0) begin
              m_state = 1'b0; mph = 0; chk_done = 1'b1; exp_done = !stopping;
            end
          end
          default: ;
        endcase
      end
    end
  end

  task automatic push(input cmd_t c, output bit acc);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_step = c.step; cmd_speed = c.speed;
    cmd_dir = c.dir; cmd_ms = c.ms;
    #1 acc = cmd_ready;
    if (acc) begin
      if (c.step != 0) exp_q.push_back(c);
      acc_cyc = cyc + 1;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || m_state) && n < budget) begin @(negedge clk); n++; end
    check_eq("idle_reached", n < budget, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_run(input int budget);
    int n = 0;
    while (!m_state && n < budget) begin @(negedge clk); n++; end
    check_eq("run_reached", m_state, 1);
  endtask

  task automatic pulse_err_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cmd_t c;
    bit   acc;
    int   s0, d0, n;

    repeat (3) @(negedge clk);
    check_eq("rst_cmd_ready", cmd_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_m_start", m_start, 0);
    check_eq("rst_m_stop", m_stop, 0);
    check_eq("rst_level", fifo_level, 0);
    check_eq("rst_err_timeout", err_timeout, 0);
    check_eq("rst_limit_hit", limit_hit, 0);
    check_eq("rst_m_step", m_step, 0);
    resetn = 1'b1;
    #1 check_eq("ready_before_first_edge", cmd_ready, 0);
    @(negedge clk);
    check_eq("ready_after_reset", cmd_ready, 1);

    // Single move with fixed fields and latency.
    ack_delay = 40; run_len = 500;
    s0 = n_starts; d0 = n_dones;
    c.step = 16'd100; c.speed = 16'h200; c.dir = 1'b1; c.ms = 3'd2;
    push(c, acc);
    check_eq("t1_accept", acc, 1);
    n = 0;
    while (n_starts == s0 && n < 10) begin @(negedge clk); n++; end
    check_eq("t1_started", n_starts - s0, 1);
    check_eq("start_latency", start_cyc - acc_cyc, 2);
    wait_idle(700);
    check_eq("t1_dones", n_dones - d0, 1);

    // Fill the queue while the first move runs.
    ack_delay = $urandom_range(1, 8); run_len = $urandom_range(60, 90);
    s0 = n_starts; d0 = n_dones;
    for (int i = 0; i < 9; i++) begin
      push(rand_cmd(), acc);
      check_eq("fill_accept", acc, 1);
    end
    push(rand_cmd(), acc);
    check_eq("full_reject", acc, 0);
    check_eq("level_full", fifo_level, 8);
    check_eq("level_vs_model", fifo_level, exp_q.size());
    wait_idle(9 * 120);
    check_eq("fill_starts", n_starts - s0, 9);
    check_eq("fill_dones", n_dones - d0, 9);
    check_eq("fill_drained", exp_q.size(), 0);

    // Zero-step command is skipped with a done pulse.
    s0 = n_starts; d0 = n_dones;
    c = rand_cmd(); c.step = '0;
    push(c, acc);
    repeat (4) @(negedge clk);
    check_eq("zero_done", n_dones - d0, 1);
    check_eq("zero_no_start", n_starts - s0, 0);
    check_eq("zero_level", fifo_level, 0);
    check_eq("zero_busy", busy, 0);

    // Start never acknowledged.
    ack_en = 1'b0;
    s0 = n_starts; d0 = n_dones;
    push(rand_cmd(), acc);
    n = 0;
    while (n_starts == s0 && n < 10) begin @(negedge clk); n++; end
    push(rand_cmd(), acc);
    push(rand_cmd(), acc);
    n = 0;
    while (!err_timeout && n < 400) begin @(negedge clk); n++; end
    check_eq("timeout_cycles", cyc - start_cyc, 255);
    check_eq("timeout_flush", fifo_level, 0);
    check_eq("timeout_no_done", n_dones - d0, 0);
    exp_q.delete();
    ack_en = 1'b1; ack_delay = 3; run_len = 10;
    push(rand_cmd(), acc);
    check_eq("held_accept", acc, 1);
    repeat (20) @(negedge clk);
    check_eq("held_no_start", n_starts - s0, 1);
    check_eq("held_level", fifo_level, 1);
    check_eq("held_flag", err_timeout, 1);
    pulse_err_clr();
    check_eq("timeout_cleared", err_timeout, 0);
    wait_idle(100);
    check_eq("held_issued", n_starts - s0, 2);
    check_eq("held_done", n_dones - d0, 1);

    // Limit during a move toward the terminal end.
    ack_delay = 4; run_len = 300;
    s0 = n_starts; d0 = n_dones;
    c = rand_cmd(); c.dir = 1'b1;
    push(c, acc);
    wait_run(20);
    push(rand_cmd(), acc);
    push(rand_cmd(), acc);
    repeat (3) @(negedge clk);
    m_zpsign = 1'b1; @(negedge clk); m_zpsign = 1'b0;
    check_eq("zp_ignored", limit_hit, 0);
    check_eq("zp_level", fifo_level, 2);
    m_tpsign = 1'b1; @(negedge clk); m_tpsign = 1'b0;
    check_eq("tp_limit", limit_hit, 1);
    check_eq("tp_flush", fifo_level, 0);
    check_eq("tp_busy", busy, 1);
    exp_q.delete();
    limit_stop = 1'b1;
    wait_idle(50);
    check_eq("limit_done", n_dones - d0, 1);
    check_eq("limit_sticky", limit_hit, 1);
    run_len = 15;
    push(rand_cmd(), acc);
    repeat (10) @(negedge clk);
    check_eq("limit_held", n_starts - s0, 1);
    pulse_err_clr();
    check_eq("limit_cleared", limit_hit, 0);
    wait_idle(100);
    check_eq("limit_resumed", n_starts - s0, 2);

    // Abort during a move with three queued.
    ack_delay = 3; run_len = 200;
    s0 = n_starts; d0 = n_dones;
    push(rand_cmd(), acc);
    wait_run(20);
    for (int i = 0; i < 3; i++) push(rand_cmd(), acc);
    check_eq("abort_level_before", fifo_level, 3);
    @(negedge clk);
    c = rand_cmd();
    abort = 1'b1; cmd_valid = 1'b1; cmd_step = c.step; cmd_speed = c.speed;
    #1 check_eq("ready_blocked_abort", cmd_ready, 0);
    @(negedge clk);
    abort = 1'b0; cmd_valid = 1'b0;
    check_eq("abort_stop", m_stop, 1);
    check_eq("abort_flush", fifo_level, 0);
    @(negedge clk);
    check_eq("stop_one_cycle", m_stop, 0);
    exp_q.delete();
    wait_idle(50);
    check_eq("abort_no_done", n_dones - d0, 0);
    check_eq("abort_starts", n_starts - s0, 1);

    // Random command stream.
    s0 = n_starts; d0 = n_dones;
    for (int i = 0; i < 6; i++) begin
      ack_delay = $urandom_range(1, 20); run_len = $urandom_range(1, 30);
      push(rand_cmd(), acc);
      check_eq("rand_accept", acc, 1);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    wait_idle(2000);
    check_eq("rand_starts", n_starts - s0, 6);
    check_eq("rand_dones", n_dones - d0, 6);
    check_eq("rand_drained", exp_q.size(), 0);

    // Reset in the middle of a move.
    ack_delay = 2; run_len = 100;
    push(rand_cmd(), acc);
    wait_run(20);
    push(rand_cmd(), acc);
    #2 resetn = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_level", fifo_level, 0);
    check_eq("midrst_m_step", m_step, 0);
    check_eq("midrst_ready", cmd_ready, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
